// File: rtl/quad_step_encoder_pkg.sv
// ------------------------------------------------------------------
// quad_pkg: FSM states, {A,B} phase constants and the phase sequencer
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package quad_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  localparam logic [1:0] PH_00 = 2'b00;
  localparam logic [1:0] PH_10 = 2'b10;
  localparam logic [1:0] PH_11 = 2'b11;
  localparam logic [1:0] PH_01 = 2'b01;

  // Up walks 00->10->11->01 (A leads B); down walks the same ring backwards.
  function automatic logic [1:0] next_phase(input logic [1:0] phase, input logic dir);
    logic [1:0] nxt;
    case (phase)
      PH_00:   nxt = dir ? PH_10 : PH_01;
      PH_10:   nxt = dir ? PH_11 : PH_00;
      PH_11:   nxt = dir ? PH_01 : PH_10;
      default: nxt = dir ? PH_00 : PH_11;
    endcase
    return nxt;
  endfunction

endpackage

`default_nettype wire

// File: rtl/quad_step_encoder_if.sv
// ------------------------------------------------------------------
// quad_step_encoder_if: step request valid/ready handshake
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

interface quad_step_encoder_if;
  logic step_valid;
  logic step_dir;
  logic step_ready;

  modport master (
    output step_valid,
    output step_dir,
    input  step_ready
  );

  modport slave (
    input  step_valid,
    input  step_dir,
    output step_ready
  );
endinterface

`default_nettype wire

// File: rtl/quad_step_encoder_hold_timer.sv
// ------------------------------------------------------------------
// quad_hold_timer: loadable down-counter that parks at zero
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module quad_hold_timer #(
  parameter int WIDTH = 3
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             load,
  input  wire logic [WIDTH-1:0] load_val,
  output logic                  zero,
  output logic                  one
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (count_q != '0) begin
      count_d = count_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == '0);
  assign one  = (count_q == WIDTH'(1));

endmodule

`default_nettype wire

// File: rtl/quad_step_encoder.sv
// ------------------------------------------------------------------
// quad_step_encoder: step commands to A/B quadrature with position mirror
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module quad_step_encoder
  import quad_pkg::*;
#(
  parameter int HOLD_CYCLES = 4,
  parameter int POS_W       = 4
) (
  input  wire logic             clk,
  input  wire logic             rst,
  quad_step_encoder_if.slave    step,
  output logic                  quad_a,
  output logic                  quad_b,
  output logic [POS_W-1:0]      position,
  output logic                  busy,
  output logic                  step_done
);

  localparam int               TMR_W      = $clog2(HOLD_CYCLES + 1);
  localparam logic [TMR_W-1:0] TMR_LOAD   = TMR_W'(HOLD_CYCLES - 1);
  localparam logic             ONE_CYCLE  = (HOLD_CYCLES == 1);

  state_t             state_q, state_d;
  logic [1:0]         phase_q, phase_d;
  logic [POS_W-1:0]   position_q, position_d;
  logic               ready_q, ready_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               accept;
  logic               tmr_zero;
  logic               tmr_one;

  quad_hold_timer #(
    .WIDTH (TMR_W)
  ) u_hold_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (accept),
    .load_val (TMR_LOAD),
    .zero     (tmr_zero),
    .one      (tmr_one)
  );

  // ready_q is cleared by reset, so nothing is accepted until one edge after release.
  assign accept = ready_q && step.step_valid;

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    position_d = position_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d    = HOLD;
          phase_d    = next_phase(phase_q, step.step_dir);
          position_d = step.step_dir ? position_q + POS_W'(1) : position_q - POS_W'(1);
        end
      end
      default: begin
        if (tmr_zero) begin
          state_d = IDLE;
        end
      end
    endcase
    // step_done is registered, so raise it one edge before the timer reaches zero.
    done_d  = accept ? ONE_CYCLE : ((state_q == HOLD) && tmr_one);
    ready_d = (state_d == IDLE);
    busy_d  = (state_d == HOLD);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      phase_q    <= PH_00;
      position_q <= '0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      position_q <= position_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign step.step_ready = ready_q;
  assign quad_a          = phase_q[1];
  assign quad_b          = phase_q[0];
  assign position        = position_q;
  assign busy            = busy_q;
  assign step_done       = done_q;

endmodule

`default_nettype wire

// File: doc/quad_step_encoder.md
Name: quad_step_encoder

Overview:
- Transmit end of the quadrature position interface: turns single-step commands (direction + valid) into A/B quadrature waveforms for an up/down counting receiver.
- Keeps an internal up/down position that mirrors the count the far end should hold.
- Sits between the motion/test controller and the quadrature counter input pins.
- Step requests use a valid/ready handshake; the minimum edge spacing is enforced by a hold timer.

Parameters:
- HOLD_CYCLES, 4: cycles each quadrature state is held after an edge before the next step is accepted. Legal range is 1..255.
- POS_W, 4: width of the position mirror, matching the 4-bit receiver count.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-low reset. Sampled on the clk rising edge; 0 = reset.
- step_valid  input  1  step request present.
- step_dir  input  1  1 = up (increment), 0 = down (decrement). Sampled with step_valid.
- step_ready  output  1  encoder can accept a step this cycle.
- quad_a  output  1  quadrature phase A, registered.
- quad_b  output  1  quadrature phase B, registered.
- position  output  POS_W  mirror of the receiver count, registered.
- busy  output  1  hold in progress; equals ~step_ready out of reset.
- step_done  output  1  one-cycle pulse when the hold of a step completes.

Behaviour:
- Reset (rst=0 at a clk edge):
  - quad_a=0, quad_b=0, position=0, step_done=0.
  - FSM goes to IDLE with the timer cleared.
  - step_ready=0 and busy=0 while rst=0; step_ready=1 on the first cycle after rst returns high.
- Phase sequence, encoded as {A,B}:
  - Up: 00 -> 10 -> 11 -> 01 -> 00 (A leads B).
  - Down: the exact reverse, 00 -> 01 -> 11 -> 10 -> 00.
  - Exactly one of A/B toggles per accepted step; both never change in the same cycle.
- FSM states:
  - IDLE: step_ready=1. On step_valid=1 at edge N, the step is accepted, the FSM moves to HOLD and the timer loads HOLD_CYCLES-1.
  - HOLD: step_ready=0, step_valid ignored (no queuing). Timer decrements each cycle. The cycle the timer reads 0, step_done=1; the FSM returns to IDLE at the next edge.
- Latency:
  - quad_a/quad_b/position update at edge N (visible in cycle N+1).
  - step_ready is low in cycles N+1 .. N+HOLD_CYCLES and high again at N+HOLD_CYCLES+1.
  - step_done is high in cycle N+HOLD_CYCLES.
  - Minimum step period is HOLD_CYCLES+1 cycles.
- Position arithmetic:
  - Up adds 1 modulo 2^POS_W (15 -> 0); down subtracts 1 modulo 2^POS_W (0 -> 15).
  - No saturation and no flags.
- Direction reversal:
  - Allowed on any step; the phase steps back one state.
  - Example: up to 10, then down returns to 00. Position moves -1 accordingly.
- step_valid held high with no new intent is treated as a new step each time step_ready=1. The requester deasserts after the handshake.
- Reset mid-HOLD: aborts the step. Outputs go to reset values at that edge; the pending step_done is never issued.
- HOLD_CYCLES=1:
  - Timer loads 0, so step_done is high in cycle N+1.
  - step_ready returns at N+2, giving a 2-cycle step period.

Decomposition:
- Package quad_pkg holds:
  - the FSM state enum {IDLE, HOLD};
  - 2-bit phase constants PH_00, PH_10, PH_11, PH_01;
  - a pure function next_phase(phase, dir) implementing the sequence table.
- One natural sub-module: quad_hold_timer. It is a loadable down-counter (width from $clog2(HOLD_CYCLES+1)) with inputs load/load_val and output zero. The top instantiates it; the FSM, phase register and position register live in the top.

Test Plan:
- Reset release: hold rst=0 for 2 cycles, then 1 -> A=B=0, position=0, step_ready=1 on the first cycle after release, step_done never pulses.
- Five up steps, HOLD_CYCLES=4, valid held high: {A,B} = 10, 11, 01, 00, 10; position = 1, 2, 3, 4, 5; accepted steps 5 cycles apart; step_done 4 cycles after each acceptance.
- Down steps from reset: {A,B} = 01, 11, 10; position = 15, 14, 13 (wrap through 0).
- Reversal: up, up, down -> {A,B} = 10, 11, 10; position = 1, 2, 1; no cycle where A and B both change.
- Valid during HOLD: step_valid pulsed at N+2 after acceptance at N -> ignored; position unchanged until the next accepted request.
- Reset mid-HOLD: accept up at N, rst=0 at N+2 -> cycle N+3 shows A=B=0, position=0, no step_done; step_ready=1 one cycle after rst returns high.
